fetch_ctl: RTL and testbench

FETCH_CTL -- requirements
Module: fetch_ctl

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_decode.sv | 32 +++
 rtl/fetch_ctl.sv | 134 +++++++++++++
 tb/tb_fetch_ctl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch controller: FSM states, opcodes, PC-control codes, NOP.
// Pure declarations, no logic.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    EXEC   = 3'd2,
    UPDATE = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_CTL_INC = 2'b00;
  localparam logic [1:0] PC_CTL_BR  = 2'b01;
  localparam logic [1:0] PC_CTL_JMP = 2'b10;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_decode.sv
// Combinational decode of the instruction register into PC-control code, branch target and halt flag.
// Zero latency; no flow control.
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int PC_BITS    = 6,
  parameter int INSTR_BITS = 16
) (
  input  logic [INSTR_BITS-1:0] ir,
  output logic [1:0]            pc_ctl,
  output logic [PC_BITS-1:0]    imm,
  output logic                  is_halt
);

  logic [3:0] opcode;
  logic       unused_bits;

  assign opcode      = ir[INSTR_BITS-1:INSTR_BITS-4];
  assign imm         = ir[PC_BITS-1:0];
  assign is_halt     = (opcode == OP_HALT);
  assign unused_bits = ^ir[INSTR_BITS-5:PC_BITS];

  always_comb begin
    pc_ctl = PC_CTL_INC;
    case (opcode)
      OP_BR:   pc_ctl = PC_CTL_BR;
      OP_JMP:  pc_ctl = PC_CTL_JMP;
      default: pc_ctl = PC_CTL_INC;
    endcase
  end

endmodule

// File: rtl/fetch_ctl.sv
// Fetch/execute sequencer: fetch on imem_req/imem_ack, hold ir_valid until exec_done, one-cycle PC strobe.
// Fetch waits for ack indefinitely unless FETCH_TIMEOUT_EN adds a 16-cycle watchdog (NOP + sticky fetch_err).
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter int PC_BITS    = 6,
  parameter int INSTR_BITS = 16
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  run,
  input  logic [PC_BITS-1:0]    pc_in,
  output logic                  imem_req,
  output logic [PC_BITS-1:0]    imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_BITS-1:0] imem_rdata,
  output logic [INSTR_BITS-1:0] ir_out,
  output logic                  ir_valid,
  input  logic                  exec_done,
  output logic                  pc_latch_data,
  output logic [1:0]            pc_ctl,
  output logic [PC_BITS-1:0]    imm,
`ifdef FETCH_TIMEOUT_EN
  output logic                  fetch_err,
`endif
  output logic                  halted
);

  state_t             state;
  logic               addr_pend;
  logic [1:0]         dec_pc_ctl;
  logic [PC_BITS-1:0] dec_imm;
  logic               dec_halt;
`ifdef FETCH_TIMEOUT_EN
  logic [3:0]         wdog;
`endif

  fetch_decode #(
    .PC_BITS    (PC_BITS),
    .INSTR_BITS (INSTR_BITS)
  ) u_decode (
    .ir      (ir_out),
    .pc_ctl  (dec_pc_ctl),
    .imm     (dec_imm),
    .is_halt (dec_halt)
  );

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr_pend     <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      ir_out        <= '0;
      ir_valid      <= 1'b0;
      pc_latch_data <= 1'b0;
      pc_ctl        <= PC_CTL_INC;
      imm           <= '0;
      halted        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wdog          <= '0;
      fetch_err     <= 1'b0;
`endif
    end else begin
      pc_latch_data <= 1'b0;
      pc_ctl        <= PC_CTL_INC;
      imm           <= '0;
`ifdef FETCH_TIMEOUT_EN
      wdog          <= '0;
`endif
      case (state)
        IDLE: begin
          if (run) begin
            state     <= REQ;
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
          end
        end
        REQ: begin
          // After a PC strobe the PC stage updates on the same edge, so the address is sampled a cycle later.
          if (addr_pend) begin
            addr_pend <= 1'b0;
            imem_addr <= pc_in;
            imem_req  <= 1'b1;
          end else if (imem_ack) begin
            ir_out   <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= EXEC;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wdog == 4'hF) begin
            ir_out    <= INSTR_BITS'(NOP_INSTR);
            ir_valid  <= 1'b1;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= EXEC;
          end else begin
            wdog <= wdog + 4'd1;
          end
`endif
        end
        EXEC: begin
          if (exec_done) begin
            ir_valid <= 1'b0;
            if (dec_halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc_latch_data <= 1'b1;
              pc_ctl        <= dec_pc_ctl;
              imm           <= dec_imm;
              state         <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (run) begin
            addr_pend <= 1'b1;
            state     <= REQ;
          end else begin
            state <= IDLE;
          end
        end
        HALT: begin
          imem_req <= 1'b0;
          ir_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl: reset, fetch latency, decode strobes, run drop, halt, reset mid-fetch.
module tb_fetch_ctl;
  import fetch_pkg::*;

  logic        clka = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  pc_in;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        exec_done;
  logic        pc_latch_data;
  logic [1:0]  pc_ctl;
  logic [5:0]  imm;
  logic        halted;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int checks = 0;
  int failures = 0;
  int req_seen;

  always #5 clka = ~clka;

  fetch_ctl #(.PC_BITS(6), .INSTR_BITS(16)) dut (
    .clka          (clka),
    .reset         (reset),
    .run           (run),
    .pc_in         (pc_in),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir_out        (ir_out),
    .ir_valid      (ir_valid),
    .exec_done     (exec_done),
    .pc_latch_data (pc_latch_data),
    .pc_ctl        (pc_ctl),
    .imm           (imm),
`ifdef FETCH_TIMEOUT_EN
    .fetch_err     (fetch_err),
`endif
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req,      0);
    check({tag, "_addr"},  imem_addr,     0);
    check({tag, "_ir"},    ir_out,        0);
    check({tag, "_vld"},   ir_valid,      0);
    check({tag, "_latch"}, pc_latch_data, 0);
    check({tag, "_ctl"},   pc_ctl,        0);
    check({tag, "_imm"},   imm,           0);
    check({tag, "_halt"},  halted,        0);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; pc_in = 6'd0; imem_ack = 1'b0;
    imem_rdata = 16'h0; exec_done = 1'b0;
    tick(2);
    check_reset_outputs("rst");
    check("rst_state", dut.state, IDLE);
    reset = 1'b1;
    tick(1);
    check("idle_req", imem_req, 0);

    // Fetch from pc 4, ack on the third REQ cycle; stray exec_done in REQ ignored.
    run = 1'b1; pc_in = 6'd4;
    tick(1);
    check("req_on", imem_req, 1);
    check("req_addr", imem_addr, 4);
    pc_in = 6'd9; exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("req_addr_stable", imem_addr, 4);
    tick(1);
    check("no_vld_before_ack", ir_valid, 0);
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick(1);
    imem_ack = 1'b0;
    check("ir_1234", ir_out, 16'h1234);
    check("vld_1234", ir_valid, 1);
    check("req_drop", imem_req, 0);
    tick(1);
    check("vld_hold", ir_valid, 1);
    check("no_early_strobe", pc_latch_data, 0);
    exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("inc_strobe", pc_latch_data, 1);
    check("inc_ctl", pc_ctl, 0);
    check("inc_imm", imm, 6'h34);
    check("upd_vld", ir_valid, 0);

    // PC settles after the strobe edge; address must be taken one cycle later.
    tick(1);
    pc_in = 6'd5;
    check("strobe_1cyc", pc_latch_data, 0);
    check("pend_no_req", imem_req, 0);
    tick(1);
    check("addr_settled", imem_addr, 5);
    check("req_again", imem_req, 1);

    // Branch opcode; a stray ack during UPDATE is ignored.
    imem_ack = 1'b1; imem_rdata = 16'hC00A;
    tick(1);
    imem_ack = 1'b0;
    check("ir_c00a", ir_out, 16'hC00A);
    exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("br_strobe", pc_latch_data, 1);
    check("br_ctl", pc_ctl, 1);
    check("br_imm", imm, 10);
    imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    tick(1);
    imem_ack = 1'b0; pc_in = 6'd7;
    check("br_strobe_off", pc_latch_data, 0);
    check("br_ctl_off", pc_ctl, 0);
    check("br_imm_off", imm, 0);
    check("stray_ack_ignored", ir_out, 16'hC00A);
    tick(1);
    check("addr_7", imem_addr, 7);

    // Jump-to-register opcode.
    imem_ack = 1'b1; imem_rdata = 16'hD000;
    tick(1);
    imem_ack = 1'b0; exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("jmp_strobe", pc_latch_data, 1);
    check("jmp_ctl", pc_ctl, 2);

    // run dropped during EXEC: instruction completes, then back to IDLE.
    tick(1);
    pc_in = 6'd8;
    tick(1);
    check("addr_8", imem_addr, 8);
    imem_ack = 1'b1; imem_rdata = 16'h1003;
    tick(1);
    imem_ack = 1'b0; run = 1'b0;
    check("runoff_vld", ir_valid, 1);
    tick(1);
    check("runoff_vld_hold", ir_valid, 1);
    exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("runoff_strobe", pc_latch_data, 1);
    check("runoff_imm", imm, 3);
    tick(1);
    check("runoff_idle", dut.state, IDLE);
    check("runoff_latch_off", pc_latch_data, 0);
    tick(1);
    check("runoff_no_req", imem_req, 0);

    // HALT is absorbing.
    run = 1'b1; pc_in = 6'h10;
    tick(1);
    check("halt_addr", imem_addr, 6'h10);
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    tick(1);
    imem_ack = 1'b0; exec_done = 1'b1;
    tick(1);
    exec_done = 1'b0;
    check("halted", halted, 1);
    check("halt_no_strobe", pc_latch_data, 0);
    check("halt_vld", ir_valid, 0);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0]; exec_done = i[1];
      tick(1);
      if (imem_req || ir_valid || pc_latch_data) req_seen++;
    end
    imem_ack = 1'b0; exec_done = 1'b0;
    check("halt_quiet_20", req_seen, 0);
    check("halt_sticky", halted, 1);

    // Reset during REQ, released with ack pending.
    reset = 1'b0;
    tick(1);
    reset = 1'b1; run = 1'b1; pc_in = 6'd3;
    tick(1);
    check("pre_rst_req", imem_req, 1);
    reset = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
    #1;
    check("async_req_drop", imem_req, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("late_ack");
    check("late_ack_state", dut.state, IDLE);
    imem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    run = 1'b1; pc_in = 6'd1;
    tick(1);
    check("to_req", imem_req, 1);
    tick(15);
    check("to_not_yet", ir_valid, 0);
    tick(1);
    check("to_vld", ir_valid, 1);
    check("to_nop", ir_out, 0);
    check("to_err", fetch_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
